fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 39 +++
 rtl/fetch_unit_branch_lut.sv | 25 ++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (IDLE / RUN / HALT)
//   BR_*          : decoder branch condition codes
//   HALT_INSTR_DEF: reserved instruction word that ends a run
//   LUT_IDX_W     : width of the branch target LUT index (instr[5:0])
//   br_taken()    : evaluates a branch condition code against ALU flags
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [1:0] BR_Z    = 2'b00;
  localparam logic [1:0] BR_N    = 2'b01;
  localparam logic [1:0] BR_AL   = 2'b10;
  localparam logic [1:0] BR_LINK = 2'b11;

  localparam logic [8:0] HALT_INSTR_DEF = 9'h1FF;

  localparam int LUT_IDX_W = 6;

  function automatic logic br_taken(input logic [1:0] src,
                                    input logic       zero_flag,
                                    input logic       neg_flag);
    logic t;
    t = 1'b0;
    case (src)
      BR_Z:    t = zero_flag;
      BR_N:    t = neg_flag;
      BR_AL:   t = 1'b1;
      BR_LINK: t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// branch_lut: constant 64-entry branch target ROM, purely combinational.
//   idx    in  LUT_IDX_W  target index (instruction low bits)
//   target out PC_W       branch destination address
// Most entries follow idx*16+3; a few hand-placed entries give short
// targets and the top-of-memory address (used to exercise PC wrap).
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      target
);

  always_comb begin
    target = '0;
    case (idx)
      6'd1:    target = '1;
      6'd2:    target = PC_W'(40);
      6'd5:    target = PC_W'(20);
      default: target = PC_W'({idx, 4'b0011});
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, flags the current
// instruction as live, and picks the next PC from the decoder's branch
// controls and the ALU flags. A start/done handshake frames each run.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        pulse: begin a run from PC 0 (ignored while running)
//   stall        freeze all fetch state this cycle
//   instr        instruction word at pc (combinational memory read)
//   branch       decoder Branch for the current instruction
//   branch_src   branch condition code (BR_Z/BR_N/BR_AL/BR_LINK)
//   zero_flag    registered ALU zero flag
//   neg_flag     registered ALU negative flag
//   pc           current fetch address (registered)
//   instr_valid  instr is live and executing this cycle (combinational)
//   link_pc      return address captured by branch-and-link (registered)
//   done         run complete, held until the next start (registered)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 9,
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(HALT_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch,
  input  logic [1:0]         branch_src,
  input  logic               zero_flag,
  input  logic               neg_flag,
  output logic [PC_W-1:0]    pc,
  output logic               instr_valid,
  output logic [PC_W-1:0]    link_pc,
  output logic               done
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] link_q, link_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] lut_target;
  logic [PC_W-1:0] pc_inc;

  branch_lut #(.PC_W(PC_W)) u_branch_lut (
    .idx    (instr[LUT_IDX_W-1:0]),
    .target (lut_target)
  );

  // Natural wrap from the top address back to 0.
  assign pc_inc = pc_q + PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      link_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      link_q  <= link_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    link_d      = link_q;
    done_d      = done_q;
    instr_valid = (state_q == RUN) && !stall;

    // Stall freezes everything, including start handling in IDLE/HALT.
    if (!stall) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            pc_d    = '0;
          end
        end
        RUN: begin
          if (instr == HALT_INSTR) begin
            state_d = HALT;
            done_d  = 1'b1;
          end else if (branch && br_taken(branch_src, zero_flag, neg_flag)) begin
            pc_d = lut_target;
            if (branch_src == BR_LINK) begin
              link_d = pc_inc;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
        HALT: begin
          if (start) begin
            state_d = RUN;
            pc_d    = '0;
            done_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          pc_d    = '0;
        end
      endcase
    end
  end

  assign pc      = pc_q;
  assign link_pc = link_q;
  assign done    = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam logic [8:0] HALT_W = 9'h1FF;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stall = 1'b0;
  logic               zero_flag = 1'b0;
  logic               neg_flag = 1'b0;
  logic [INSTR_W-1:0] instr;
  logic               branch;
  logic [1:0]         branch_src;
  logic [PC_W-1:0]    pc;
  logic               instr_valid;
  logic [PC_W-1:0]    link_pc;
  logic               done;

  // Instruction memory and per-address decoder outputs, read at the DUT pc.
  logic [8:0] imem [1024];
  logic       bmem [1024];
  logic [1:0] smem [1024];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    instr      = imem[pc];
    branch     = bmem[pc];
    branch_src = smem[pc];
  end

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .instr       (instr),
    .branch      (branch),
    .branch_src  (branch_src),
    .zero_flag   (zero_flag),
    .neg_flag    (neg_flag),
    .pc          (pc),
    .instr_valid (instr_valid),
    .link_pc     (link_pc),
    .done        (done)
  );

  // Reference branch target table, written as plain arithmetic.
  function automatic logic [9:0] ref_lut(input int idx);
    if (idx == 1) return 10'd1023;
    if (idx == 2) return 10'd40;
    if (idx == 5) return 10'd20;
    return 10'(idx * 16 + 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      imem[i] = 9'h000;
      bmem[i] = 1'b0;
      smem[i] = 2'b00;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    rst_n = 1'b0;
    #2;
    tests++; if (pc !== 10'd0) begin fails++; $display("FAIL reset_pc got %0d exp 0", pc); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (link_pc !== 10'd0) begin fails++; $display("FAIL reset_link got %0d exp 0", link_pc); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tests++; if (pc !== 10'd0 || instr_valid !== 1'b0) begin fails++; $display("FAIL idle_hold pc %0d valid %b exp 0 0", pc, instr_valid); end
  endtask

  task automatic test_sequential();
    int vcount;
    clear_mem();
    imem[3] = HALT_W;
    vcount = 0;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      tests++; if (pc !== 10'(k)) begin fails++; $display("FAIL seq_pc got %0d exp %0d", pc, k); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL seq_done_early got %b exp 0", done); end
      if (instr_valid === 1'b1) vcount++;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      if (instr_valid === 1'b1) vcount++;
      tests++; if (pc !== 10'd3 || done !== 1'b1) begin fails++; $display("FAIL seq_halt pc %0d done %b exp 3 1", pc, done); end
      tick();
    end
    tests++; if (vcount != 4) begin fails++; $display("FAIL seq_valid_cycles got %0d exp 4", vcount); end
  endtask

  task automatic test_cond_branch();
    clear_mem();
    bmem[0] = 1'b1; smem[0] = 2'b00; imem[0] = 9'h005;
    bmem[20] = 1'b1; smem[20] = 2'b00; imem[20] = 9'h005;
    imem[21] = HALT_W;
    zero_flag = 1'b1;
    pulse_start();
    tests++; if (pc !== 10'd0 || done !== 1'b0) begin fails++; $display("FAIL restart pc %0d done %b exp 0 0", pc, done); end
    tick();
    tests++; if (pc !== 10'd20) begin fails++; $display("FAIL br_z_taken got %0d exp 20", pc); end
    zero_flag = 1'b0;
    tick();
    tests++; if (pc !== 10'd21) begin fails++; $display("FAIL br_z_not_taken got %0d exp 21", pc); end
    tick();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL br_halt_done got %b exp 1", done); end
  endtask

  task automatic test_link();
    clear_mem();
    bmem[7] = 1'b1; smem[7] = 2'b11; imem[7] = 9'h002;
    imem[40] = HALT_W;
    pulse_start();
    repeat (7) tick();
    tests++; if (pc !== 10'd7) begin fails++; $display("FAIL link_pre_pc got %0d exp 7", pc); end
    tick();
    tests++; if (pc !== 10'd40) begin fails++; $display("FAIL link_target got %0d exp 40", pc); end
    tests++; if (link_pc !== 10'd8) begin fails++; $display("FAIL link_pc got %0d exp 8", link_pc); end
    tick();
  endtask

  task automatic test_stall();
    clear_mem();
    bmem[12] = 1'b1; smem[12] = 2'b10; imem[12] = 9'h009;
    imem[147] = HALT_W;
    pulse_start();
    repeat (12) tick();
    stall = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stall_valid got %b exp 0", instr_valid); end
      tick();
      tests++; if (pc !== 10'd12) begin fails++; $display("FAIL stall_pc got %0d exp 12", pc); end
    end
    stall = 1'b0;
    #1;
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL unstall_valid got %b exp 1", instr_valid); end
    tick();
    tests++; if (pc !== 10'd147) begin fails++; $display("FAIL stall_branch got %0d exp 147", pc); end
    tests++; if (link_pc !== 10'd8) begin fails++; $display("FAIL stall_link_hold got %0d exp 8", link_pc); end
    tick();
  endtask

  task automatic test_wrap_restart();
    clear_mem();
    bmem[0] = 1'b1; smem[0] = 2'b00; imem[0] = 9'h001;
    imem[1] = HALT_W;
    zero_flag = 1'b1;
    pulse_start();
    tick();
    tests++; if (pc !== 10'd1023) begin fails++; $display("FAIL wrap_top got %0d exp 1023", pc); end
    zero_flag = 1'b0;
    tick();
    tests++; if (pc !== 10'd0) begin fails++; $display("FAIL wrap_zero got %0d exp 0", pc); end
    tick();
    tick();
    tests++; if (done !== 1'b1 || pc !== 10'd1) begin fails++; $display("FAIL wrap_halt done %b pc %0d exp 1 1", done, pc); end
    pulse_start();
    tests++; if (pc !== 10'd0 || done !== 1'b0) begin fails++; $display("FAIL halt_restart pc %0d done %b exp 0 0", pc, done); end
  endtask

  task automatic test_async_reset();
    clear_mem();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    pulse_start();
    repeat (30) tick();
    tests++; if (pc !== 10'd30) begin fails++; $display("FAIL ar_pre_pc got %0d exp 30", pc); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (pc !== 10'd0 || done !== 1'b0 || instr_valid !== 1'b0 || link_pc !== 10'd0)
      begin fails++; $display("FAIL ar_async pc %0d done %b valid %b link %0d exp 0 0 0 0", pc, done, instr_valid, link_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++; if (pc !== 10'd0 || instr_valid !== 1'b0) begin fails++; $display("FAIL ar_idle pc %0d valid %b exp 0 0", pc, instr_valid); end
    pulse_start();
    tests++; if (pc !== 10'd0 || instr_valid !== 1'b1) begin fails++; $display("FAIL ar_start pc %0d valid %b exp 0 1", pc, instr_valid); end
    tick();
    tests++; if (pc !== 10'd1) begin fails++; $display("FAIL ar_run pc got %0d exp 1", pc); end
  endtask

  task automatic test_random();
    int         m_mode;
    logic [9:0] m_pc, m_link;
    logic       m_done, taken, exp_valid;
    logic [8:0] w;
    for (int i = 0; i < 1024; i++) begin
      imem[i] = ($urandom_range(0, 99) < 4) ? HALT_W : 9'($urandom_range(0, 510));
      bmem[i] = ($urandom_range(0, 99) < 30);
      smem[i] = 2'($urandom_range(0, 3));
    end
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    #2; rst_n = 1'b1;
    m_mode = 0; m_pc = '0; m_link = '0; m_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 99) < 10);
      stall     = ($urandom_range(0, 99) < 20);
      zero_flag = 1'($urandom_range(0, 1));
      neg_flag  = 1'($urandom_range(0, 1));
      #1;
      exp_valid = (m_mode == 1) && !stall;
      tests++; if (instr_valid !== exp_valid) begin fails++; if (fails < 20) $display("FAIL rnd_valid cyc %0d got %b exp %b", c, instr_valid, exp_valid); end
      if (!stall) begin
        if (m_mode == 0 && start) begin
          m_mode = 1; m_pc = '0;
        end else if (m_mode == 1) begin
          w = imem[m_pc];
          taken = (smem[m_pc] >= 2'd2) || (smem[m_pc] == 2'd0 && zero_flag) ||
                  (smem[m_pc] == 2'd1 && neg_flag);
          if (w == HALT_W) begin
            m_mode = 2; m_done = 1'b1;
          end else if (bmem[m_pc] && taken) begin
            if (smem[m_pc] == 2'd3) m_link = m_pc + 10'd1;
            m_pc = ref_lut(int'(w[5:0]));
          end else begin
            m_pc = m_pc + 10'd1;
          end
        end else if (m_mode == 2 && start) begin
          m_mode = 1; m_pc = '0; m_done = 1'b0;
        end
      end
      tick();
      tests++; if (pc !== m_pc) begin fails++; if (fails < 20) $display("FAIL rnd_pc cyc %0d got %0d exp %0d", c, pc, m_pc); end
      tests++; if (link_pc !== m_link) begin fails++; if (fails < 20) $display("FAIL rnd_link cyc %0d got %0d exp %0d", c, link_pc, m_link); end
      tests++; if (done !== m_done) begin fails++; if (fails < 20) $display("FAIL rnd_done cyc %0d got %b exp %b", c, done, m_done); end
    end
    start = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_cond_branch();
    test_link();
    test_stall();
    test_wrap_restart();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
